// File: rtl/rvfi_chk_pkg.sv
// Shared types for the RVFI retirement-stream checker: error codes, FSM states,
// and the per-lane arbitration order.
package rvfi_chk_pkg;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_LANE      = 3'd1,
    ERR_ORDER     = 3'd2,
    ERR_PC        = 3'd3,
    ERR_X0        = 3'd4,
    ERR_POST_HALT = 3'd5,
    ERR_HANG      = 3'd6
  } rvfi_err_e;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALTED   = 3'd3,
    ST_FAIL     = 3'd4
  } chk_state_e;

  // Within one lane the lowest rank wins; across lanes the lowest lane wins.
  localparam int unsigned PRIO_LANE  = 0;
  localparam int unsigned PRIO_ORDER = 1;
  localparam int unsigned PRIO_PC    = 2;
  localparam int unsigned PRIO_X0    = 3;

endpackage

// File: rtl/rvfi_lane_check.sv
// Combinational checks for one retirement lane; reports the highest-priority
// violation seen on that lane this cycle.
module rvfi_lane_check
  import rvfi_chk_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            en,
  input  logic            seq_en,
  input  logic            valid,
  input  logic            pred_valid,
  input  logic            pred_trap,
  input  logic [63:0]     order,
  input  logic [63:0]     exp_order,
  input  logic [XLEN-1:0] pc_rdata,
  input  logic [XLEN-1:0] exp_pc,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_wdata,
  output rvfi_err_e       err
);

  always_comb begin
    err = ERR_NONE;
    if (en && valid) begin
      if (!pred_valid)                                   err = ERR_LANE;
      else if (seq_en && order != exp_order)             err = ERR_ORDER;
      else if (seq_en && !pred_trap && pc_rdata != exp_pc) err = ERR_PC;
      else if (rd_addr == 5'd0 && rd_wdata != '0)        err = ERR_X0;
    end
  end

endmodule

// File: rtl/rvfi_stream_checker.sv
// RVFI retirement-stream checker: order/PC chaining, x0, lane contiguity,
// post-halt and hang detection, with a sticky first-error record.
module rvfi_stream_checker
  import rvfi_chk_pkg::*;
#(
  parameter int NRET    = 1,
  parameter int XLEN    = 32,
  parameter int ILEN    = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 check,
  input  logic                 clear,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [NRET*64-1:0]   rvfi_order,
  input  logic [NRET*ILEN-1:0] rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [NRET*5-1:0]    rvfi_rd_addr,
  input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
  input  logic [NRET*XLEN-1:0] rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0] rvfi_pc_wdata,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [1:0]           err_lane,
  output logic [63:0]          err_order,
  output logic [ILEN-1:0]      err_insn,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [2:0]           state
);

  chk_state_e      st_q, st_d;
  rvfi_err_e       code_q, det_code;
  logic [63:0]     exp_order, det_order, last_order;
  logic [XLEN-1:0] exp_pc, last_pc_w;
  logic            exp_vld;
  logic [31:0]     to_cnt;
  logic            lane_en, seq_en, cnt_en, any_vld, any_halt, det, det_new, idle_run;
  logic [1:0]      det_lane;
  logic [ILEN-1:0] det_insn;
  logic [2:0]      n_ret;
  logic [CNT_W:0]  cnt_sum;
  rvfi_err_e       lane_err [NRET];
  logic            unused_trap;

  // The top lane's trap has no successor in the same cycle.
  assign unused_trap = rvfi_trap[NRET-1];

  assign lane_en  = check && (st_q == ST_ARMED || st_q == ST_RUN);
  assign seq_en   = check && st_q == ST_RUN && exp_vld;
  assign cnt_en   = check && (st_q == ST_ARMED || st_q == ST_RUN || st_q == ST_HALTED);
  assign any_vld  = |rvfi_valid;
  assign any_halt = |(rvfi_valid & rvfi_halt);
  assign idle_run = check && st_q == ST_RUN && TIMEOUT > 0 && !any_vld;

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    logic            pv, pt;
    logic [XLEN-1:0] epc;
    if (i == 0) begin : g_head
      assign pv  = 1'b1;
      assign pt  = 1'b0;
      assign epc = exp_pc;
    end else begin : g_tail
      assign pv  = rvfi_valid[i-1];
      assign pt  = rvfi_trap[i-1];
      assign epc = rvfi_pc_wdata[(i-1)*XLEN +: XLEN];
    end
    rvfi_lane_check #(.XLEN(XLEN)) u_chk (
      .en(lane_en), .seq_en(seq_en), .valid(rvfi_valid[i]),
      .pred_valid(pv), .pred_trap(pt),
      .order(rvfi_order[i*64 +: 64]), .exp_order(exp_order + 64'(i)),
      .pc_rdata(rvfi_pc_rdata[i*XLEN +: XLEN]), .exp_pc(epc),
      .rd_addr(rvfi_rd_addr[i*5 +: 5]), .rd_wdata(rvfi_rd_wdata[i*XLEN +: XLEN]),
      .err(lane_err[i])
    );
  end

  always_comb begin
    n_ret      = '0;
    last_pc_w  = '0;
    last_order = '0;
    for (int i = 0; i < NRET; i++) begin
      if (rvfi_valid[i]) begin
        n_ret      = n_ret + 3'd1;
        last_pc_w  = rvfi_pc_wdata[i*XLEN +: XLEN];
        last_order = rvfi_order[i*64 +: 64];
      end
    end
    cnt_sum = {1'b0, retire_cnt} + (CNT_W+1)'(n_ret);

    det = 1'b0; det_code = ERR_NONE; det_lane = '0; det_order = '0; det_insn = '0;
    // Descending scan so the lowest failing lane is the one kept.
    for (int i = NRET-1; i >= 0; i--) begin
      if (lane_err[i] != ERR_NONE) begin
        det       = 1'b1;
        det_code  = lane_err[i];
        det_lane  = 2'(i);
        det_order = rvfi_order[i*64 +: 64];
        det_insn  = rvfi_insn[i*ILEN +: ILEN];
      end
    end
    if (check && st_q == ST_HALTED && any_vld) begin
      det = 1'b1; det_code = ERR_POST_HALT; det_lane = '0;
      det_order = rvfi_order[63:0]; det_insn = rvfi_insn[ILEN-1:0];
    end
    if (idle_run && to_cnt >= 32'(TIMEOUT - 1)) begin
      det = 1'b1; det_code = ERR_HANG; det_lane = '0;
      det_order = exp_order; det_insn = '0;
    end
    det_new = det && !err && !clear;
  end

  always_comb begin
    st_d = st_q;
    if (!check && st_q != ST_FAIL) st_d = ST_DISABLED;
    else if (det_new)              st_d = ST_FAIL;
    else begin
      case (st_q)
        ST_DISABLED: st_d = ST_ARMED;
        ST_ARMED:    if (any_vld)  st_d = ST_RUN;
        ST_RUN:      if (any_halt) st_d = ST_HALTED;
        ST_FAIL:     if (clear)    st_d = ST_DISABLED;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_DISABLED;
    else        st_q <= st_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0; code_q <= ERR_NONE; err_lane <= '0; err_order <= '0; err_insn <= '0;
      retire_cnt <= '0; to_cnt <= '0; exp_order <= '0; exp_pc <= '0; exp_vld <= 1'b0;
    end else if (clear) begin
      err <= 1'b0; code_q <= ERR_NONE; err_lane <= '0; err_order <= '0; err_insn <= '0;
      retire_cnt <= '0; to_cnt <= '0; exp_order <= '0; exp_pc <= '0; exp_vld <= 1'b0;
    end else begin
      if (det_new) begin
        err <= 1'b1; code_q <= det_code; err_lane <= det_lane;
        err_order <= det_order; err_insn <= det_insn;
      end
      if (cnt_en) retire_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      if (!idle_run)                     to_cnt <= '0;
      else if (to_cnt < 32'(TIMEOUT))    to_cnt <= to_cnt + 32'd1;
      // The first retirement after arming only seeds the expectations.
      if (!check) exp_vld <= 1'b0;
      else if (lane_en && any_vld && !det) begin
        exp_order <= exp_vld ? exp_order + 64'(n_ret) : last_order + 64'd1;
        exp_pc    <= last_pc_w;
        exp_vld   <= 1'b1;
      end
    end
  end

  assign err_code = code_q;
  assign state    = st_q;

endmodule

// File: tb/tb_rvfi_stream_checker.sv
// Bench for rvfi_stream_checker: a single-lane instance with a short hang
// timeout and a two-lane instance with the hang check disabled.
module tb_rvfi_stream_checker;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;

  logic        ck1 = 0, cl1 = 0;
  logic [0:0]  v1 = '0, t1 = '0, h1 = '0;
  logic [63:0] o1 = '0;
  logic [31:0] i1 = '0, rw1 = '0, pr1 = '0, pw1 = '0;
  logic [4:0]  ra1 = '0;
  logic        e1;
  logic [2:0]  ec1, st1;
  logic [1:0]  el1;
  logic [63:0] eo1;
  logic [31:0] ei1, rc1;

  logic         ck2 = 0, cl2 = 0;
  logic [1:0]   v2 = '0, t2 = '0, h2 = '0;
  logic [127:0] o2 = '0;
  logic [63:0]  i2 = '0, rw2 = '0, pr2 = '0, pw2 = '0;
  logic [9:0]   ra2 = '0;
  logic         e2;
  logic [2:0]   ec2, st2;
  logic [1:0]   el2;
  logic [63:0]  eo2;
  logic [31:0]  ei2, rc2;

  rvfi_stream_checker #(.NRET(1), .TIMEOUT(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .check(ck1), .clear(cl1),
    .rvfi_valid(v1), .rvfi_order(o1), .rvfi_insn(i1), .rvfi_trap(t1), .rvfi_halt(h1),
    .rvfi_rd_addr(ra1), .rvfi_rd_wdata(rw1), .rvfi_pc_rdata(pr1), .rvfi_pc_wdata(pw1),
    .err(e1), .err_code(ec1), .err_lane(el1), .err_order(eo1), .err_insn(ei1),
    .retire_cnt(rc1), .state(st1));

  rvfi_stream_checker #(.NRET(2), .TIMEOUT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .check(ck2), .clear(cl2),
    .rvfi_valid(v2), .rvfi_order(o2), .rvfi_insn(i2), .rvfi_trap(t2), .rvfi_halt(h2),
    .rvfi_rd_addr(ra2), .rvfi_rd_wdata(rw2), .rvfi_pc_rdata(pr2), .rvfi_pc_wdata(pw2),
    .err(e2), .err_code(ec2), .err_lane(el2), .err_order(eo2), .err_insn(ei2),
    .retire_cnt(rc2), .state(st2));

  // Reference model of the legal two-lane stream.
  logic [63:0] m_order;
  logic [31:0] m_pc;
  int          m_cnt;

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set1(input logic [63:0] ord, input logic [31:0] pc, input logic [31:0] npc,
                      input logic [4:0] rd, input logic [31:0] wd, input logic halt);
    v1 = 1'b1; o1 = ord; pr1 = pc; pw1 = npc; ra1 = rd; rw1 = wd; h1 = halt; t1 = 1'b0;
    i1 = $urandom;
  endtask

  task automatic idle1(); v1 = 1'b0; h1 = 1'b0; endtask

  task automatic restart1();
    idle1(); ck1 = 1'b0; cl1 = 1'b1; tick(); cl1 = 1'b0; ck1 = 1'b1; tick();
  endtask

  task automatic restart2();
    v2 = '0; ck2 = 1'b0; cl2 = 1'b1; tick(); cl2 = 1'b0; ck2 = 1'b1; tick();
  endtask

  task automatic set2(input int l, input logic [63:0] ord, input logic [31:0] pc,
                      input logic [31:0] npc, input logic [4:0] rd, input logic [31:0] wd);
    v2[l] = 1'b1; o2[l*64 +: 64] = ord; pr2[l*32 +: 32] = pc; pw2[l*32 +: 32] = npc;
    ra2[l*5 +: 5] = rd; rw2[l*32 +: 32] = wd; i2[l*32 +: 32] = $urandom; t2[l] = 1'b0;
  endtask

  // Drive n legal retirements continuing the model stream.
  task automatic gen2(input int n);
    logic [31:0] pc, npc;
    v2 = '0; t2 = '0; h2 = '0;
    pc = m_pc; npc = m_pc;
    for (int l = 0; l < n; l++) begin
      v2[l] = 1'b1;
      o2[l*64 +: 64] = m_order + 64'(l);
      i2[l*32 +: 32] = $urandom;
      pr2[l*32 +: 32] = pc;
      npc = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'h3) : pc + 32'd4;
      pw2[l*32 +: 32] = npc;
      t2[l] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ra2[l*5 +: 5] = 5'd0; rw2[l*32 +: 32] = 32'd0;
      end else begin
        ra2[l*5 +: 5] = 5'($urandom_range(1, 31)); rw2[l*32 +: 32] = $urandom;
      end
      pc = t2[l] ? $urandom : npc;
    end
    m_order = m_order + 64'(n);
    if (n > 0) m_pc = npc;
    m_cnt += n;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({e1, ec1, el1, eo1, ei1, rc1, st1} !== '0) begin
      n_err++; $display("FAIL reset1 got st=%0d err=%0b cnt=%0d, want all zero", st1, e1, rc1);
    end
    n_chk++;
    if ({e2, ec2, el2, eo2, ei2, rc2, st2} !== '0) begin
      n_err++; $display("FAIL reset2 got st=%0d err=%0b cnt=%0d, want all zero", st2, e2, rc2);
    end
    rst_n = 1'b1; tick();
    n_chk++;
    if (st1 !== 3'd0) begin n_err++; $display("FAIL idle_disabled got %0d want 0", st1); end
    ck1 = 1'b1; tick();
    n_chk++;
    if (st1 !== 3'd1) begin n_err++; $display("FAIL armed got %0d want 1", st1); end
  endtask

  task automatic test_stream();
    logic [63:0] base;
    logic [31:0] pc;
    for (int pass = 0; pass < 2; pass++) begin
      restart1();
      base = (pass == 0) ? 64'd0 : 64'd0 - 64'($urandom_range(1, 8));
      pc   = (pass == 0) ? 32'd0 : ($urandom & ~32'h3);
      for (int k = 0; k < 10; k++) begin
        set1(base + 64'(k), pc + 32'(4*k), pc + 32'(4*k + 4), 5'($urandom_range(1, 31)), $urandom, 1'b0);
        tick();
      end
      idle1();
      n_chk++;
      if ({e1, rc1, st1} !== {1'b0, 32'd10, 3'd2}) begin
        n_err++; $display("FAIL stream%0d got err=%0b cnt=%0d st=%0d want 0/10/2", pass, e1, rc1, st1);
      end
    end
    ck1 = 1'b0; tick();
    n_chk++;
    if ({st1, rc1} !== {3'd0, 32'd10}) begin
      n_err++; $display("FAIL check_drop got st=%0d cnt=%0d want 0/10", st1, rc1);
    end
  endtask

  task automatic test_order_gap();
    logic [31:0] p, ins;
    restart1();
    p = $urandom & ~32'h3;
    set1(64'd3, p, p + 32'd4, 5'd1, 32'd1, 1'b0); tick();
    set1(64'd5, p + 32'd4, p + 32'd8, 5'd1, 32'd1, 1'b0); ins = i1; tick();
    n_chk++;
    if ({e1, ec1, el1, eo1, ei1, st1} !== {1'b1, 3'd2, 2'd0, 64'd5, ins, 3'd4}) begin
      n_err++; $display("FAIL order_gap got err=%0b code=%0d order=%0d st=%0d want 1/2/5/4", e1, ec1, eo1, st1);
    end
    set1(64'd6, p + 32'd8, p + 32'd12, 5'd0, 32'd9, 1'b0); tick(); idle1();
    n_chk++;
    if ({ec1, eo1} !== {3'd2, 64'd5}) begin
      n_err++; $display("FAIL sticky got code=%0d order=%0d want 2/5", ec1, eo1);
    end
  endtask

  task automatic test_hang();
    logic [63:0] b;
    restart1();
    b = {$urandom, $urandom};
    set1(b, 32'h40, 32'h44, 5'd2, 32'd3, 1'b0); tick(); idle1();
    repeat (7) tick();
    n_chk++;
    if (e1 !== 1'b0) begin n_err++; $display("FAIL hang_early got err=%0b want 0", e1); end
    tick();
    n_chk++;
    if ({e1, ec1, el1, eo1, ei1} !== {1'b1, 3'd6, 2'd0, b + 64'd1, 32'd0}) begin
      n_err++; $display("FAIL hang got err=%0b code=%0d order=%h want 1/6/%h", e1, ec1, eo1, b + 64'd1);
    end
  endtask

  task automatic test_halt_clear();
    logic [31:0] ins;
    restart1();
    for (int k = 0; k < 4; k++) begin
      set1(64'(k), 32'(4*k), 32'(4*k + 4), 5'd1, 32'd0, k == 3); tick();
    end
    idle1();
    n_chk++;
    if ({e1, st1} !== {1'b0, 3'd3}) begin
      n_err++; $display("FAIL halted got err=%0b st=%0d want 0/3", e1, st1);
    end
    set1(64'd4, 32'd16, 32'd20, 5'd1, 32'd0, 1'b0); ins = i1; tick(); idle1();
    n_chk++;
    if ({e1, ec1, el1, eo1, ei1, rc1} !== {1'b1, 3'd5, 2'd0, 64'd4, ins, 32'd5}) begin
      n_err++; $display("FAIL post_halt got code=%0d order=%0d cnt=%0d want 5/4/5", ec1, eo1, rc1);
    end
    cl1 = 1'b1; tick(); cl1 = 1'b0;
    n_chk++;
    if ({e1, ec1, rc1, st1} !== {1'b0, 3'd0, 32'd0, 3'd0}) begin
      n_err++; $display("FAIL clear got err=%0b code=%0d cnt=%0d st=%0d want 0/0/0/0", e1, ec1, rc1, st1);
    end
    tick();
    n_chk++;
    if (st1 !== 3'd1) begin n_err++; $display("FAIL rearm got %0d want 1", st1); end
  endtask

  task automatic test_clear_vs_error();
    restart1();
    set1(64'd0, 32'd0, 32'd4, 5'd1, 32'd0, 1'b0); tick();
    set1(64'd7, 32'd4, 32'd8, 5'd1, 32'd0, 1'b0); cl1 = 1'b1; tick(); cl1 = 1'b0; idle1();
    n_chk++;
    if ({e1, ec1, rc1} !== {1'b0, 3'd0, 32'd0}) begin
      n_err++; $display("FAIL clear_wins got err=%0b code=%0d cnt=%0d want 0/0/0", e1, ec1, rc1);
    end
  endtask

  task automatic test_pc_chain();
    logic [63:0] b;
    for (int tr = 0; tr < 2; tr++) begin
      restart2();
      b = {$urandom, $urandom};
      v2 = '0; set2(0, b, 32'h10, 32'h20, 5'd1, 32'd0); tick();
      set2(0, b + 64'd1, 32'h20, 32'h100, 5'd1, 32'd0); t2[0] = (tr == 1);
      set2(1, b + 64'd2, 32'h104, 32'h108, 5'd1, 32'd0); tick(); v2 = '0;
      n_chk++;
      if (tr == 0) begin
        if ({e2, ec2, el2, eo2} !== {1'b1, 3'd3, 2'd1, b + 64'd2}) begin
          n_err++; $display("FAIL pc_chain got code=%0d lane=%0d want 3/1", ec2, el2);
        end
      end else if ({e2, rc2, st2} !== {1'b0, 32'd3, 3'd2}) begin
        n_err++; $display("FAIL pc_trap_skip got err=%0b cnt=%0d st=%0d want 0/3/2", e2, rc2, st2);
      end
    end
  endtask

  task automatic test_lane_gap();
    logic [63:0] b;
    restart2();
    b = {$urandom, $urandom};
    v2 = '0; set2(0, b, 32'h0, 32'h4, 5'd1, 32'd0); tick();
    v2 = '0; set2(1, b + 64'd1, 32'h4, 32'h8, 5'd0, 32'd7); tick(); v2 = '0;
    n_chk++;
    if ({e2, ec2, el2, eo2} !== {1'b1, 3'd1, 2'd1, b + 64'd1}) begin
      n_err++; $display("FAIL lane_gap got code=%0d lane=%0d want 1/1", ec2, el2);
    end
  endtask

  task automatic test_no_timeout();
    restart2();
    v2 = '0; set2(0, 64'd0, 32'h0, 32'h4, 5'd1, 32'd0); tick(); v2 = '0;
    repeat (100) tick();
    n_chk++;
    if ({e2, st2} !== {1'b0, 3'd2}) begin
      n_err++; $display("FAIL no_timeout got err=%0b st=%0d want 0/2", e2, st2);
    end
  endtask

  task automatic test_random_stream();
    int f, l;
    logic [2:0]  xc;
    logic [63:0] xo;
    logic [31:0] xi;
    for (int it = 0; it < 8; it++) begin
      restart2();
      m_order = (it[0]) ? 64'd0 - 64'($urandom_range(1, 40)) : {$urandom, $urandom};
      m_pc = $urandom & ~32'h3; m_cnt = 0;
      gen2($urandom_range(1, 2)); tick();
      for (int c = 0; c < 25; c++) begin gen2($urandom_range(0, 2)); tick(); end
      v2 = '0;
      n_chk++;
      if ({e2, rc2, st2} !== {1'b0, 32'(m_cnt), 3'd2}) begin
        n_err++; $display("FAIL rand_stream%0d got err=%0b code=%0d cnt=%0d st=%0d want cnt=%0d", it, e2, ec2, rc2, st2, m_cnt);
      end
      gen2(2);
      f = $urandom_range(0, 3); l = $urandom_range(0, 1);
      case (f)
        0: begin v2[0] = 1'b0; l = 1; xc = 3'd1; end
        1: begin o2[l*64 +: 64] = o2[l*64 +: 64] + 64'($urandom_range(1, 5)); xc = 3'd2; end
        2: begin
          if (l == 0) pr2[31:0] = pr2[31:0] ^ 32'h10;
          else begin t2[0] = 1'b0; pr2[63:32] = pw2[31:0] ^ 32'h10; end
          xc = 3'd3;
        end
        default: begin ra2[l*5 +: 5] = 5'd0; rw2[l*32 +: 32] = $urandom | 32'd1; xc = 3'd4; end
      endcase
      xo = o2[l*64 +: 64]; xi = i2[l*32 +: 32];
      tick(); v2 = '0;
      n_chk++;
      if ({e2, ec2, el2, eo2, ei2, st2} !== {1'b1, xc, 2'(l), xo, xi, 3'd4}) begin
        n_err++; $display("FAIL rand_fault%0d got code=%0d lane=%0d order=%h want %0d/%0d/%h", it, ec2, el2, eo2, xc, l, xo);
      end
    end
  endtask

  task automatic test_async_reset();
    restart1();
    set1(64'd0, 32'd0, 32'd4, 5'd1, 32'd0, 1'b0); tick();
    set1(64'd9, 32'd4, 32'd8, 5'd1, 32'd0, 1'b0); tick(); idle1();
    rst_n = 1'b0; #2;
    n_chk++;
    if ({e1, ec1, el1, eo1, ei1, rc1, st1} !== '0) begin
      n_err++; $display("FAIL async_reset got err=%0b cnt=%0d st=%0d want all zero", e1, rc1, st1);
    end
    rst_n = 1'b1; tick();
  endtask

  initial begin
    tick(); tick();
    test_reset();
    test_stream();
    test_order_gap();
    test_hang();
    test_halt_clear();
    test_clear_vs_error();
    test_pc_chain();
    test_lane_gap();
    test_no_timeout();
    test_random_stream();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_stream_checker.md
Name: rvfi_stream_checker

Overview:
- Synthesizable, parametrised RVFI retirement-stream checker for the formal and simulation benches.
- Taps the core's RVFI bus for NRET retirement lanes and checks that the order field increments with no gaps, that the PC chains from one instruction to the next, that x0 is never written non-zero, that valid lanes are contiguous, that nothing retires after a halt, and that the core does not hang.
- Latches the first violation with its context and keeps a retirement counter.
- Sits beside the causal check in the bench. Gated by `check` (processor init_done).

Parameters:
- NRET, 1, retirement lanes per cycle (1..4).
- XLEN, 32, register/PC width.
- ILEN, 32, instruction width.
- TIMEOUT, 1024, cycles in RUN with no retirement before HANG is flagged; 0 disables the check.
- CNT_W, 32, width of the retirement counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- check  in  1  enable; checking is active only while high.
- clear  in  1  synchronous clear of the sticky error and the counter.
- rvfi_valid  in  NRET  lane retires.
- rvfi_order  in  NRET*64  instruction order per lane.
- rvfi_insn  in  NRET*ILEN  instruction word.
- rvfi_trap  in  NRET  trap flag.
- rvfi_halt  in  NRET  halt flag.
- rvfi_rd_addr  in  NRET*5  destination register.
- rvfi_rd_wdata  in  NRET*XLEN  destination write data.
- rvfi_pc_rdata  in  NRET*XLEN  PC of the retiring instruction.
- rvfi_pc_wdata  in  NRET*XLEN  next PC.
- err  out  1  sticky error flag.
- err_code  out  3  first error: 0 NONE, 1 LANE, 2 ORDER, 3 PC, 4 X0, 5 POST_HALT, 6 HANG.
- err_lane  out  2  lane of the first error.
- err_order  out  64  order value of the failing retirement (expected order for HANG).
- err_insn  out  ILEN  instruction word of the failing retirement (0 for HANG).
- retire_cnt  out  CNT_W  retirements seen while enabled; saturates at all-ones.
- state  out  3  FSM state.

Behaviour:
- Reset values: all outputs 0, state DISABLED, expectations invalid, timeout counter 0.
- FSM states: DISABLED, ARMED, RUN, HALTED, FAIL.
  - DISABLED -> ARMED when check=1.
  - ARMED -> RUN on the first cycle with any valid lane.
  - RUN -> HALTED when a valid lane has halt=1.
  - Any state except DISABLED -> FAIL on a detected error.
  - check=0 in any state except FAIL -> DISABLED; expectations are invalidated and retire_cnt is held.
  - FAIL holds until clear=1, then goes to DISABLED.
- Error outputs are registered: err and the err_* fields update on the cycle after detection.
- First retirement in ARMED: sets the baseline. exp_order = order+1 and exp_pc = pc_wdata of the last valid lane. ORDER and PC are not checked on this retirement; LANE and X0 are.
- Per-lane checks in RUN (lane i, in the same cycle):
  - LANE: valid[i]=1 while valid[i-1]=0.
  - ORDER: order[i] != exp_order+i.
  - PC: pc_rdata[i] != expected PC. Lane 0 expects exp_pc; lane i>0 expects pc_wdata[i-1]. The check is skipped if the predecessor trapped.
  - X0: rd_addr=0 with rd_wdata!=0.
- POST_HALT: any valid lane while in HALTED.
- HANG: in RUN with TIMEOUT>0, the counter increments on each cycle with no valid lane and clears on any retirement. HANG is flagged when it reaches TIMEOUT. The counter saturates and does not wrap.
- Simultaneous errors: the lowest lane wins. Within a lane the priority is LANE > ORDER > PC > X0. POST_HALT and HANG are reported as lane 0.
- Only the first error is latched. Once err=1 further violations are ignored until clear.
- On each retiring cycle with no error: exp_order += popcount(valid), exp_pc = pc_wdata of the highest valid lane.
- retire_cnt += popcount(valid) while state is ARMED, RUN or HALTED, saturating.
- clear: zeroes err, err_*, retire_cnt, the timeout counter and the expectations. If clear and a new error occur in the same cycle, clear wins.
- Asynchronous reset mid-run returns everything to reset values immediately.
- Widths: order arithmetic is 64-bit modulo, so wrap from all-ones to 0 is legal.

Decomposition:
- Package rvfi_chk_pkg (or added to defines), holding:
  - rvfi_err_e, 3-bit enum of the codes above.
  - chk_state_e, 3-bit enum of the FSM states.
  - Priority constants for error arbitration.
- Sub-module rvfi_lane_check: combinational per-lane comparator.
  - Inputs: lane signals, expected order, expected PC, predecessor trap, predecessor valid.
  - Output: rvfi_err_e.
  - Instantiated NRET times by a generate loop.

Test Plan:
- NRET=1: check=1, retire orders 0..9 with pc 0x0,0x4,…, pc_wdata=pc+4 -> err=0, retire_cnt=10, state RUN.
- NRET=1: order 5 follows order 3 -> next cycle err=1, err_code=2, err_order=5, state FAIL; a later X0 fault leaves err_code unchanged.
- NRET=2: lane0 pc_wdata=0x100, lane1 pc_rdata=0x104 -> err_code=3, err_lane=1. Repeat with lane0 trap=1 -> no error.
- NRET=2: valid=2'b10 -> err_code=1, err_lane=1. Same cycle with x0 write on lane 1 -> still err_code=1.
- TIMEOUT=8: retire once, then idle 8 cycles -> err_code=6. With TIMEOUT=0, idle 100 cycles -> err=0.
- halt on order 3, then a valid retirement -> err_code=5. Then clear=1 -> err=0, retire_cnt=0, state DISABLED, then ARMED while check=1.
